// File: rtl/dac_wave_sequencer.sv
// -----------------------------------------------------------------------------
// dac_wave_sequencer
//
// Sample source for the DAC7611 serial driver. Once per programmable sample
// period it computes one WIDTH-bit DAC code (sawtooth, triangle, square or
// constant) and offers it to the serializer over a valid/ready handshake.
// When a new sample is due but the previous one is still waiting, the new one
// is dropped and counted in a saturating overrun counter.
//
// Ports
//   clk_X4        in   system clock shared with the serializer (rising edge)
//   rst_n         in   synchronous reset, active low
//   enable        in   1 runs the generator, 0 returns it to idle
//   mode          in   0 sawtooth, 1 triangle, 2 square, 3 constant
//   step          in   code increment per sample (sawtooth/triangle)
//   low_code      in   lower waveform bound
//   high_code     in   upper waveform bound
//   divisor       in   sample period is divisor+1 clock cycles
//   sample_data   out  code offered to the serializer
//   sample_valid  out  sample_data holds an untransferred code
//   sample_ready  in   serializer accepts sample_data this cycle
//   overrun_cnt   out  samples dropped since reset, saturating
//   running       out  high while the generator runs
// -----------------------------------------------------------------------------
module dac_wave_sequencer #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned DIV_W = 16,
   parameter int unsigned OVR_W = 8
) (
   input  logic             clk_X4,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] step,
   input  logic [WIDTH-1:0] low_code,
   input  logic [WIDTH-1:0] high_code,
   input  logic [DIV_W-1:0] divisor,
   output logic [WIDTH-1:0] sample_data,
   output logic             sample_valid,
   input  logic             sample_ready,
   output logic [OVR_W-1:0] overrun_cnt,
   output logic             running
);

   typedef enum logic [0:0] {StIdle, StRun} state_t;

   localparam logic [1:0] ModeSaw   = 2'd0;
   localparam logic [1:0] ModeTri   = 2'd1;
   localparam logic [1:0] ModeSq    = 2'd2;
   localparam logic [1:0] ModeConst = 2'd3;

   // dir encoding: 0 = up, 1 = down
   localparam logic DirUp   = 1'b0;
   localparam logic DirDown = 1'b1;

   state_t state_q, state_d;

   logic [DIV_W-1:0] div_cnt_q;
   logic [DIV_W-1:0] div_lim_q;
   logic [WIDTH-1:0] acc_q;
   logic             dir_q;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic [OVR_W-1:0] ovr_q;

   logic             enter_run;
   logic             leave_run;
   logic             run_active;
   logic             tick;
   logic             xfer;

   logic [WIDTH-1:0] cur;
   logic [WIDTH-1:0] acc_nxt;
   logic             dir_nxt;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   low_plus_step;
   logic             misconfig;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_X4) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (enable)  state_d = StRun;
         StRun:   if (!enable) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM: outputs and state-derived strobes
   always_comb begin
      running    = (state_q == StRun);
      enter_run  = (state_q == StIdle) && enable;
      leave_run  = (state_q == StRun) && !enable;
      run_active = (state_q == StRun) && enable;
   end

   // ---------------------------------------------------------------------------
   // Sample-period divider. The limit is latched on entry and at every wrap so
   // a divisor change never truncates or stretches the period in progress.
   // ---------------------------------------------------------------------------
   assign tick = run_active && (div_cnt_q == div_lim_q);

   always_ff @(posedge clk_X4) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
         div_lim_q <= '0;
      end else if (enter_run) begin
         div_cnt_q <= '0;
         div_lim_q <= divisor;
      end else if (run_active) begin
         if (tick) begin
            div_cnt_q <= '0;
            div_lim_q <= divisor;
         end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Waveform generator: current code and accumulator/direction update.
   // Sums are formed one bit wider so bound comparisons cannot wrap.
   // ---------------------------------------------------------------------------
   assign sum_ext       = {1'b0, acc_q} + {1'b0, step};
   assign low_plus_step = {1'b0, low_code} + {1'b0, step};
   assign misconfig     = (low_code > high_code);

   always_comb begin
      cur     = acc_q;
      acc_nxt = acc_q;
      dir_nxt = dir_q;
      if (misconfig) begin
         // Inverted bounds: park on low_code until software fixes them.
         cur     = low_code;
         acc_nxt = low_code;
      end else begin
         unique case (mode)
            ModeSaw: begin
               cur = acc_q;
               if (sum_ext > {1'b0, high_code}) begin
                  acc_nxt = low_code;
               end else begin
                  acc_nxt = sum_ext[WIDTH-1:0];
               end
            end
            ModeTri: begin
               cur = acc_q;
               if (dir_q == DirUp) begin
                  if (sum_ext >= {1'b0, high_code}) begin
                     acc_nxt = high_code;
                     dir_nxt = DirDown;
                  end else begin
                     acc_nxt = sum_ext[WIDTH-1:0];
                  end
               end else begin
                  if ({1'b0, acc_q} < low_plus_step) begin
                     acc_nxt = low_code;
                     dir_nxt = DirUp;
                  end else begin
                     acc_nxt = acc_q - step;
                  end
               end
            end
            ModeSq: begin
               cur     = (dir_q == DirUp) ? low_code : high_code;
               dir_nxt = ~dir_q;
            end
            ModeConst: begin
               cur = high_code;
            end
            default: begin
               cur = acc_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk_X4) begin
      if (!rst_n) begin
         acc_q <= '0;
         dir_q <= DirUp;
      end else if (enter_run) begin
         acc_q <= low_code;
         dir_q <= DirUp;
      end else if (tick) begin
         // The waveform advances even when the resulting sample is dropped.
         acc_q <= acc_nxt;
         dir_q <= dir_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Output handshake and overrun accounting
   // ---------------------------------------------------------------------------
   assign xfer = valid_q && sample_ready;

   always_ff @(posedge clk_X4) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= '0;
      end else if (leave_run) begin
         // Pending sample is discarded; overrun count survives.
         valid_q <= 1'b0;
      end else if (run_active) begin
         if (tick) begin
            if (!valid_q || xfer) begin
               data_q  <= cur;
               valid_q <= 1'b1;
            end else if (ovr_q != {OVR_W{1'b1}}) begin
               ovr_q <= ovr_q + OVR_W'(1);
            end
         end else if (xfer) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign sample_data  = data_q;
   assign sample_valid = valid_q;
   assign overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_dac_wave_sequencer.sv
module tb_dac_wave_sequencer;

   localparam int W  = 12;
   localparam int DW = 16;
   localparam int OW = 8;

   logic          clk_X4 = 1'b0;
   logic          rst_n;
   logic          enable;
   logic [1:0]    mode;
   logic [W-1:0]  step;
   logic [W-1:0]  low_code;
   logic [W-1:0]  high_code;
   logic [DW-1:0] divisor;
   logic [W-1:0]  sample_data;
   logic          sample_valid;
   logic          sample_ready;
   logic [OW-1:0] overrun_cnt;
   logic          running;

   int            checks   = 0;
   int            failures = 0;
   logic [W-1:0]  sb[$];
   bit            mon_en = 1'b0;

   int            vcnt;
   logic [W-1:0]  held;
   logic [W-1:0]  d0;
   logic [W-1:0]  e;

   always #5 clk_X4 = ~clk_X4;

   dac_wave_sequencer #(
      .WIDTH(W),
      .DIV_W(DW),
      .OVR_W(OW)
   ) dut (
      .clk_X4      (clk_X4),
      .rst_n       (rst_n),
      .enable      (enable),
      .mode        (mode),
      .step        (step),
      .low_code    (low_code),
      .high_code   (high_code),
      .divisor     (divisor),
      .sample_data (sample_data),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .overrun_cnt (overrun_cnt),
      .running     (running)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step_clk(input int n);
      repeat (n) begin
         @(posedge clk_X4);
         #1;
      end
   endtask

   // Wait (bounded) for the scoreboard to empty; a leftover entry is a failure.
   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         step_clk(1);
         n++;
      end
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   // Scoreboard: every transfer pops the next expected code.
   always @(negedge clk_X4) begin
      if (mon_en && sample_valid && sample_ready) begin
         checks++;
         assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL sb_unexpected observed=0x%0h expected=no_transfer", sample_data);
         end
         if (sb.size() != 0) chk("sb_code", 32'(sample_data), 32'(sb.pop_front()));
      end
   end

   initial begin
      // ---------------- reset ----------------
      rst_n        = 1'b0;
      enable       = 1'b1;
      sample_ready = 1'b1;
      mode         = 2'd0;
      step         = 12'h010;
      low_code     = 12'h100;
      high_code    = 12'h130;
      divisor      = 16'd3;
      sb.push_back(12'h100); sb.push_back(12'h110); sb.push_back(12'h120);
      sb.push_back(12'h130); sb.push_back(12'h100); sb.push_back(12'h110);
      sb.push_back(12'h120); sb.push_back(12'h130);
      mon_en = 1'b1;
      step_clk(2);
      chk("rst_data", 32'(sample_data), 32'd0);
      chk("rst_valid", 32'(sample_valid), 32'd0);
      chk("rst_ovr", 32'(overrun_cnt), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      rst_n = 1'b1;
      step_clk(1);
      chk("run_rise", 32'(running), 32'd1);
      step_clk(3);
      chk("first_valid_early", 32'(sample_valid), 32'd0);
      step_clk(1);
      chk("first_valid", 32'(sample_valid), 32'd1);
      chk("first_data", 32'(sample_data), 32'h100);

      // ---------------- sawtooth ----------------
      vcnt = 0;
      repeat (16) begin
         step_clk(1);
         if (sample_valid) vcnt++;
      end
      chk("saw_duty", 32'(vcnt), 32'd4);
      drain("saw_drain", 40);
      mon_en = 1'b0;
      enable = 1'b0;
      step_clk(2);
      chk("idle_running", 32'(running), 32'd0);
      chk("idle_valid", 32'(sample_valid), 32'd0);

      // ---------------- triangle ----------------
      mode      = 2'd1;
      low_code  = 12'h000;
      high_code = 12'h020;
      step      = 12'h00C;
      divisor   = 16'd0;
      sb.push_back(12'h000); sb.push_back(12'h00C); sb.push_back(12'h018);
      sb.push_back(12'h020); sb.push_back(12'h014); sb.push_back(12'h008);
      sb.push_back(12'h000); sb.push_back(12'h00C); sb.push_back(12'h018);
      mon_en = 1'b1;
      enable = 1'b1;
      drain("tri_drain", 40);
      mon_en = 1'b0;
      enable = 1'b0;
      step_clk(2);

      // ---------------- backpressure (square) ----------------
      mode         = 2'd2;
      low_code     = 12'h000;
      high_code    = 12'hFFF;
      divisor      = 16'd1;
      sample_ready = 1'b0;
      sb.push_back(12'h000); sb.push_back(12'hFFF); sb.push_back(12'h000);
      mon_en = 1'b1;
      enable = 1'b1;
      step_clk(1);
      chk("bp_running", 32'(running), 32'd1);
      step_clk(2);
      chk("bp_first_valid", 32'(sample_valid), 32'd1);
      chk("bp_first_data", 32'(sample_data), 32'h000);
      repeat (8) begin
         step_clk(1);
         chk("bp_hold_valid", 32'(sample_valid), 32'd1);
         chk("bp_hold_data", 32'(sample_data), 32'h000);
      end
      chk("bp_ovr", 32'(overrun_cnt), 32'd4);
      sample_ready = 1'b1;
      drain("bp_drain", 20);
      chk("bp_no_extra_drop", 32'(overrun_cnt), 32'd4);
      mon_en = 1'b0;
      enable = 1'b0;
      step_clk(2);

      // ---------------- saturation + tick with transfer ----------------
      mode         = 2'd0;
      low_code     = 12'h000;
      high_code    = 12'hFFF;
      step         = 12'h001;
      divisor      = 16'd0;
      sample_ready = 1'b0;
      enable       = 1'b1;
      step_clk(300);
      chk("sat_cnt", 32'(overrun_cnt), 32'hFF);
      step_clk(5);
      chk("sat_hold", 32'(overrun_cnt), 32'hFF);
      chk("sat_valid", 32'(sample_valid), 32'd1);
      held = sample_data;
      chk("sat_held_code", 32'(held), 32'h000);
      sample_ready = 1'b1;
      step_clk(1);
      d0 = sample_data;
      chk("sat_new_code", 32'(d0 != held), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         step_clk(1);
         e = d0 + W'(k);
         chk("sat_cont_valid", 32'(sample_valid), 32'd1);
         chk("sat_cont_data", 32'(sample_data), 32'(e));
         chk("sat_cont_ovr", 32'(overrun_cnt), 32'hFF);
      end

      // ---------------- enable drop mid-handshake ----------------
      sample_ready = 1'b0;
      step_clk(1);
      chk("drop_pre_valid", 32'(sample_valid), 32'd1);
      enable = 1'b0;
      step_clk(1);
      chk("drop_valid", 32'(sample_valid), 32'd0);
      chk("drop_running", 32'(running), 32'd0);
      chk("drop_ovr", 32'(overrun_cnt), 32'hFF);
      low_code     = 12'h200;
      high_code    = 12'h230;
      step         = 12'h010;
      sample_ready = 1'b1;
      sb.push_back(12'h200); sb.push_back(12'h210); sb.push_back(12'h220);
      sb.push_back(12'h230); sb.push_back(12'h200);
      mon_en = 1'b1;
      enable = 1'b1;
      drain("restart_drain", 30);
      mon_en = 1'b0;
      enable = 1'b0;
      step_clk(2);

      // ---------------- inverted bounds ----------------
      mode      = 2'd1;
      low_code  = 12'h300;
      high_code = 12'h100;
      sb.push_back(12'h300); sb.push_back(12'h300); sb.push_back(12'h300);
      mon_en = 1'b1;
      enable = 1'b1;
      drain("misconfig_drain", 20);
      mon_en = 1'b0;
      enable = 1'b0;
      step_clk(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dac_wave_sequencer.md
Name: dac_wave_sequencer

Overview:
- Upstream sample source for the DAC7611 serial driver.
- Produces one 12-bit DAC code per programmable sample period: sawtooth, triangle, square or constant.
- Presents each code to the serializer over a valid/ready handshake and counts samples dropped because the serializer was still busy.
- Runs in the same clk_X4 domain as the serializer.

Parameters:
- WIDTH, 12, DAC code width; matches the DAC7611 data word.
- DIV_W, 16, width of the sample-period divisor.
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- clk_X4  in  1  system clock, shared with the DAC serializer; all logic on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- enable  in  1  high runs the generator; low returns it to IDLE.
- mode  in  2  waveform select: 0 sawtooth, 1 triangle, 2 square, 3 constant.
- step  in  WIDTH  code increment per sample (sawtooth/triangle).
- low_code  in  WIDTH  lower waveform bound.
- high_code  in  WIDTH  upper waveform bound.
- divisor  in  DIV_W  sample period = divisor+1 clk_X4 cycles.
- sample_data  out  WIDTH  code offered to the serializer.
- sample_valid  out  1  sample_data holds an untransferred code.
- sample_ready  in  1  serializer accepts sample_data this cycle.
- overrun_cnt  out  OVR_W  samples dropped since reset; saturates at all-ones.
- running  out  1  high in RUN state.

Behaviour:
Reset (rst_n low at clock edge):
- sample_data=0, sample_valid=0, overrun_cnt=0, running=0.
- Internal acc=0, dir=up, div_cnt=0, state IDLE.
- Reset has priority over every other input, including mid-handshake.

FSM, two states:
- IDLE -> RUN when enable=1. On entry to RUN, acc<=low_code, dir<=up, div_cnt<=0.
- RUN -> IDLE when enable=0. On exit, sample_valid<=0 (any pending sample discarded); overrun_cnt holds.
- running=1 exactly while in RUN.

Divider (RUN only):
- div_cnt counts 0..divisor; tick is asserted in the cycle div_cnt==divisor, and div_cnt returns to 0.
- divisor=0 gives a tick every cycle.
- The first tick occurs divisor+1 cycles after entering RUN.
- divisor changes take effect at the next wrap.

On tick, the emitted code is cur = f(mode, acc):
- Sawtooth: cur=acc. Compute acc+step in WIDTH+1 bits; if the sum > high_code then acc<=low_code, else acc<=sum.
- Triangle: cur=acc.
  - dir=up: if acc+step >= high_code then acc<=high_code and dir<=down; else acc<=acc+step.
  - dir=down: if acc < low_code+step (WIDTH+1-bit compare) then acc<=low_code and dir<=up; else acc<=acc-step.
- Square: cur=low_code when dir=up, high_code when dir=down; dir toggles each tick; acc unchanged.
- Constant: cur=high_code; acc unchanged.
- Misconfiguration low_code > high_code: cur=low_code on every tick, acc<=low_code.
- step=0 in sawtooth/triangle: cur repeats acc.
- Mode changes take effect at the next tick; acc and dir carry over.

Handshake:
- A transfer occurs in a cycle where sample_valid and sample_ready are both 1.
- Tick with sample_valid=0, or with a transfer in the same cycle: sample_data<=cur, sample_valid<=1 next cycle. Back-to-back samples are allowed; no overrun.
- Tick with sample_valid=1 and sample_ready=0: the sample is dropped. sample_data and sample_valid are unchanged, acc/dir still advance, and overrun_cnt increments, saturating.
- Transfer without a tick: sample_valid<=0.
- While sample_valid=1, sample_data must not change until a transfer occurs.
- sample_ready is ignored when sample_valid=0.

Latency: 1 cycle from tick to sample_valid rising.

Test Plan:
- Reset: rst_n=0 for 2 cycles with enable=1, ready=1 -> all outputs 0; running rises 1 cycle after release; first valid sample arrives divisor+2 cycles after release.
- Sawtooth: low=0x100, high=0x130, step=0x10, divisor=3, ready tied 1 -> codes 0x100,0x110,0x120,0x130,0x100,...; valid high 1 cycle in every 4.
- Triangle: low=0, high=0x020, step=0x0C, divisor=0, ready=1 -> codes 0x000,0x00C,0x018,0x020,0x014,0x008,0x000,0x00C,...
- Backpressure: square with low=0x000, high=0xFFF, divisor=1, ready held 0 for 10 cycles then 1 -> sample_data stays 0x000 and valid stays 1 throughout; overrun_cnt=4; on release, a new code appears the next tick with no extra drop.
- Saturation and tick+transfer: divisor=0, ready=0 for 300 cycles -> overrun_cnt=0xFF and holds. Then ready=1 -> valid stays continuously 1, a new code every cycle, overrun_cnt unchanged.
- Enable drop mid-handshake: valid=1, ready=0, enable->0 -> next cycle valid=0, running=0, overrun_cnt held. Re-enable -> sequence restarts from low_code.
